// File: rtl/cache_types_pkg.sv
// Shared widths, types and helpers for the cache-line to memory-burst adaptor.
package cache_types_pkg;

  localparam int unsigned LINE_WIDTH  = 256;
  localparam int unsigned BEAT_WIDTH  = 64;
  localparam int unsigned BEATS       = LINE_WIDTH / BEAT_WIDTH;
  localparam int unsigned OFFSET_BITS = 5;
  localparam int unsigned CNT_WIDTH   = $clog2(BEATS);

  typedef logic [LINE_WIDTH-1:0] line_t;
  typedef logic [BEAT_WIDTH-1:0] beat_t;
  typedef logic [CNT_WIDTH-1:0]  cnt_t;

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} burst_state_t;

  // Return line with beat slot idx replaced by beat (beat 0 is the LSBs).
  function automatic line_t insert_beat(line_t line, cnt_t idx, beat_t beat);
    line_t res;
    res = line;
    res[idx*BEAT_WIDTH +: BEAT_WIDTH] = beat;
    return res;
  endfunction

endpackage

// File: rtl/burst_line_buffer.sv
// Line-wide register with a beat-indexed write port, a beat read slice and a full-line port.
module burst_line_buffer
  import cache_types_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_line_i,
  input  logic [LINE_WIDTH-1:0] line_i,
  input  logic                  beat_we_i,
  input  logic [CNT_WIDTH-1:0]  beat_idx_i,
  input  logic [BEAT_WIDTH-1:0] beat_i,
  input  logic [CNT_WIDTH-1:0]  rd_idx_i,
  output logic [BEAT_WIDTH-1:0] beat_o,
  output logic [LINE_WIDTH-1:0] line_o
);

  line_t buf_q;

  // Full-line load wins over a beat write; the FSM never asserts both.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_q <= '0;
    end else if (load_line_i) begin
      buf_q <= line_i;
    end else if (beat_we_i) begin
      buf_q <= insert_beat(buf_q, beat_idx_i, beat_i);
    end
  end

  // Read ports are purely combinational views of the register.
  always_comb begin
    beat_o = buf_q[rd_idx_i*BEAT_WIDTH +: BEAT_WIDTH];
    line_o = buf_q;
  end

endmodule

// File: rtl/cacheline_burst_adaptor.sv
// Turns one 256-bit cache line fill/writeback into a 4-beat 64-bit memory burst.
module cacheline_burst_adaptor
  import cache_types_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           line_addr_i,
  input  logic                  line_read_i,
  input  logic                  line_write_i,
  input  logic [LINE_WIDTH-1:0] line_wdata_i,
  output logic [LINE_WIDTH-1:0] line_rdata_o,
  output logic                  resp_o,
  output logic [31:0]           mem_addr_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic [BEAT_WIDTH-1:0] mem_wdata_o,
  input  logic [BEAT_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_resp_i
);

  burst_state_t state_q;
  cnt_t         cnt_q;
  logic [31:0]  addr_q;
  line_t        rdata_q;
  logic         resp_q;
  logic         mem_read_q;
  logic         mem_write_q;

  logic  buf_load;
  logic  buf_beat_we;
  logic  last_beat;
  beat_t buf_beat;
  line_t buf_line;

  // Offset bits are replaced by zeros in the memory address.
  logic  unused_offset;
  assign unused_offset = ^line_addr_i[OFFSET_BITS-1:0];

  // Buffer strobes: latch the line on write accept, capture beats during a fill.
  always_comb begin
    buf_load    = (state_q == IDLE) && line_write_i;
    buf_beat_we = (state_q == RD_BURST) && mem_resp_i;
    last_beat   = mem_resp_i && (cnt_q == cnt_t'(BEATS - 1));
  end

  burst_line_buffer u_buf (
    .clk         (clk),
    .rst         (rst),
    .load_line_i (buf_load),
    .line_i      (line_wdata_i),
    .beat_we_i   (buf_beat_we),
    .beat_idx_i  (cnt_q),
    .beat_i      (mem_rdata_i),
    .rd_idx_i    (cnt_q),
    .beat_o      (buf_beat),
    .line_o      (buf_line)
  );

  // Burst FSM, beat counter and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      rdata_q     <= '0;
      resp_q      <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (line_write_i) begin
            addr_q      <= {line_addr_i[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            mem_write_q <= 1'b1;
            state_q     <= WR_BURST;
          end else if (line_read_i) begin
            addr_q     <= {line_addr_i[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            mem_read_q <= 1'b1;
            state_q    <= RD_BURST;
          end
        end
        RD_BURST: begin
          if (mem_resp_i) begin
            cnt_q <= cnt_q + 1'b1;
          end
          if (last_beat) begin
            // The last beat is merged here since the buffer only holds it after this edge.
            rdata_q    <= insert_beat(buf_line, cnt_q, mem_rdata_i);
            mem_read_q <= 1'b0;
            resp_q     <= 1'b1;
            state_q    <= DONE;
          end
        end
        WR_BURST: begin
          if (mem_resp_i) begin
            cnt_q <= cnt_q + 1'b1;
          end
          if (last_beat) begin
            mem_write_q <= 1'b0;
            resp_q      <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          resp_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Write beat is only driven while a write burst is in progress.
  always_comb begin
    mem_wdata_o  = (state_q == WR_BURST) ? buf_beat : '0;
    mem_addr_o   = addr_q;
    mem_read_o   = mem_read_q;
    mem_write_o  = mem_write_q;
    resp_o       = resp_q;
    line_rdata_o = rdata_q;
  end

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Scoreboard bench: driver pushes expected line transfers, a negedge monitor checks them.
module tb_cacheline_burst_adaptor;
  import cache_types_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] line_addr_i = '0;
  logic        line_read_i = 1'b0;
  logic        line_write_i = 1'b0;
  line_t       line_wdata_i = '0;
  line_t       line_rdata_o;
  logic        resp_o;
  logic [31:0] mem_addr_o;
  logic        mem_read_o;
  logic        mem_write_o;
  beat_t       mem_wdata_o;
  beat_t       mem_rdata_i = '0;
  logic        mem_resp_i = 1'b0;

  cacheline_burst_adaptor dut (
    .clk          (clk),
    .rst          (rst),
    .line_addr_i  (line_addr_i),
    .line_read_i  (line_read_i),
    .line_write_i (line_write_i),
    .line_wdata_i (line_wdata_i),
    .line_rdata_o (line_rdata_o),
    .resp_o       (resp_o),
    .mem_addr_o   (mem_addr_o),
    .mem_read_o   (mem_read_o),
    .mem_write_o  (mem_write_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_resp_i   (mem_resp_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    line_t       line;
  } exp_t;

  exp_t  exp_q[$];
  line_t ref_mem[logic [31:0]];   // what the cache intends memory to hold
  line_t phys_mem[logic [31:0]];  // what the bus actually wrote

  int tests = 0;
  int fails = 0;
  int wait_mode = 0;   // 0: ack every cycle, 1: random waits, 2: ack every 3rd cycle
  bit spurious = 1'b0; // random acks with junk data while no burst is active
  int resp_seen = 0;

  task automatic check(string name, logic [255:0] act, logic [255:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic line_t init_line(logic [31:0] a);
    line_t l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = (a ^ 32'h5A5A_0000) + 32'(i) * 32'h0101_0101;
    return l;
  endfunction

  function automatic line_t ref_get(logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_line(a);
  endfunction

  function automatic line_t phys_get(logic [31:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : init_line(a);
  endfunction

  function automatic line_t rand_line();
    line_t l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // Memory responder and scoreboard monitor, both sampling away from the rising edge.
  int          bidx = 0;
  int          tick = 0;
  bit          in_burst = 1'b0;
  bit          burst_wr = 1'b0;
  bit          prev_resp = 1'b0;
  logic [31:0] burst_addr = '0;
  line_t       wr_line = '0;
  line_t       rd_line = '0;

  always @(negedge clk) begin
    exp_t e;
    bit   ack;
    if (!rst) begin
      bidx = 0; in_burst = 0; prev_resp = 0; mem_resp_i = 0;
    end else begin
      if (mem_read_o && mem_write_o) check("dual_request", 1, 0);
      if (prev_resp) check("idle_after_done", {mem_read_o, mem_write_o}, 2'b00);
      if (resp_o) begin
        resp_seen++;
        if (prev_resp) check("resp_single_cycle", 1, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("burst_kind", burst_wr, e.is_wr);
          check("burst_addr", burst_addr, e.addr);
          check("beat_count", bidx, 4);
          if (e.is_wr) check("written_line", phys_get(e.addr), e.line);
          else check("fill_line", line_rdata_o, e.line);
        end
        in_burst = 0;
        bidx = 0;
      end
      prev_resp = resp_o;

      if (mem_read_o || mem_write_o) begin
        if (!in_burst) begin
          in_burst = 1; burst_wr = mem_write_o; burst_addr = mem_addr_o; bidx = 0;
          rd_line = phys_get(mem_addr_o);
        end
        check("addr_stable", mem_addr_o, burst_addr);
        check("addr_offset_zero", mem_addr_o[4:0], 5'd0);
        if (burst_wr && bidx < 4 && exp_q.size() > 0 && exp_q[0].is_wr)
          check("wdata_beat", mem_wdata_o, exp_q[0].line[bidx*64 +: 64]);
        tick++;
        case (wait_mode)
          0:       ack = 1;
          1:       ack = ($urandom_range(0, 2) == 0);
          default: ack = (tick % 3 == 0);
        endcase
        if (bidx >= 4) ack = 0;
        if (ack) begin
          if (burst_wr) begin
            wr_line[bidx*64 +: 64] = mem_wdata_o;
            if (bidx == 3) phys_mem[burst_addr] = wr_line;
          end else begin
            mem_rdata_i = rd_line[bidx*64 +: 64];
          end
          bidx++;
        end
        mem_resp_i = ack;
      end else begin
        tick = 0;
        mem_resp_i = spurious && ($urandom_range(0, 1) == 1);
        mem_rdata_i = 64'hDEAD_DEAD_DEAD_DEAD;
      end
    end
  end

  task automatic wait_resp(string name);
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (resp_o) begin ok = 1; break; end
    end
    if (!ok) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic do_req(bit wr, logic [31:0] addr, line_t data);
    logic [31:0] a;
    a = {addr[31:5], 5'b0};
    if (wr) ref_mem[a] = data;
    exp_q.push_back('{is_wr: wr, addr: a, line: ref_get(a)});
    line_addr_i = addr; line_wdata_i = data;
    line_write_i = wr; line_read_i = !wr;
    @(negedge clk);
    // Inputs changing after acceptance must not affect the burst.
    line_wdata_i = rand_line();
    line_addr_i = $urandom;
    wait_resp(wr ? "write" : "read");
    line_write_i = 0; line_read_i = 0;
  endtask

  initial begin
    line_t       l;
    logic [31:0] pool[4];
    int          n;
    int          rs;
    bit          ok;

    repeat (3) @(negedge clk);
    check("reset_outputs", {resp_o, mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o},
          '0);
    check("reset_rdata", line_rdata_o, '0);
    #2 rst = 1;

    // Directed fill with no wait states; resp_o lands in the 6th cycle counting the request cycle.
    @(negedge clk);
    l = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    ref_mem[32'h1234_5660] = l; phys_mem[32'h1234_5660] = l;
    exp_q.push_back('{is_wr: 0, addr: 32'h1234_5660, line: l});
    line_addr_i = 32'h1234_5678; line_read_i = 1;
    n = 0; ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); n++;
      if (resp_o) begin ok = 1; break; end
    end
    check("fill_seen", ok, 1);
    check("fill_latency", n, 5);
    line_read_i = 0;

    // Writeback acked every third cycle.
    @(negedge clk);
    wait_mode = 2;
    l = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
    do_req(1, 32'h0000_4A1F, l);

    // Both requests high: write goes first, then the read of the same line.
    @(negedge clk);
    wait_mode = 0;
    l = rand_line();
    ref_mem[32'h0000_8000] = l;
    exp_q.push_back('{is_wr: 1, addr: 32'h0000_8000, line: l});
    exp_q.push_back('{is_wr: 0, addr: 32'h0000_8000, line: l});
    line_addr_i = 32'h0000_8004; line_wdata_i = l; line_write_i = 1; line_read_i = 1;
    @(negedge clk);
    check("priority_write", {mem_write_o, mem_read_o}, 2'b10);
    wait_resp("prio_write");
    line_write_i = 0;
    wait_resp("prio_read");
    line_read_i = 0;

    // Reset two beats into a fill: outputs drop immediately, no resp_o for it.
    @(negedge clk);
    line_addr_i = 32'h0000_C000; line_read_i = 1;
    repeat (3) @(negedge clk);
    #1 rst = 0; line_read_i = 0;
    #1 check("async_reset_ctl", {resp_o, mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o},
             '0);
    check("async_reset_rdata", line_rdata_o, '0);
    exp_q.delete();
    @(negedge clk);
    #2 rst = 1;
    @(negedge clk);
    do_req(0, 32'h0000_C010, '0);

    // Spurious acks while idle must not produce a response.
    @(negedge clk);
    spurious = 1;
    rs = resp_seen;
    repeat (12) @(negedge clk);
    check("spurious_no_resp", resp_seen, rs);
    do_req(0, 32'h1234_5660, '0);

    // Read held across DONE with a new address: next burst after one idle cycle.
    @(negedge clk);
    exp_q.push_back('{is_wr: 0, addr: 32'h0001_0000, line: ref_get(32'h0001_0000)});
    exp_q.push_back('{is_wr: 0, addr: 32'h0002_0020, line: ref_get(32'h0002_0020)});
    line_addr_i = 32'h0001_0003; line_read_i = 1;
    wait_resp("b2b_first");
    line_addr_i = 32'h0002_003C;
    @(negedge clk);
    check("b2b_idle_gap", mem_read_o, 0);
    @(negedge clk);
    check("b2b_start", mem_read_o, 1);
    check("b2b_addr", mem_addr_o, 32'h0002_0020);
    wait_resp("b2b_second");
    line_read_i = 0;

    // Random mix over a small address pool so reads revisit written lines.
    wait_mode = 1;
    for (int i = 0; i < 4; i++) pool[i] = {$urandom_range(0, 32'h00FF_FFFF), 3'(i), 5'd0};
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      do_req($urandom_range(0, 1) == 1, pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 31)),
             rand_line());
    end

    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
